// File: rtl/vending_pkg.sv
// vending_pkg: FSM state encoding and coin denominations shared by the vending controller
package vending_pkg;
  typedef enum logic [2:0] {IDLE, COLLECTING, VEND, HOLD, CHANGE} state_e;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;
endpackage

// File: rtl/vending_controller_change_payout.sv
// change_payout: greedy change-coin picker gated by the hopper handshake
// en: in CHANGE; hopper_ready: hopper can take a coin; credit: remaining credit
// pay_5/10/25: one coin this cycle; credit_o: credit after this cycle's coin
module change_payout
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                en,
  input  logic                hopper_ready,
  input  logic [CREDIT_W-1:0] credit,
  output logic                pay_5,
  output logic                pay_10,
  output logic                pay_25,
  output logic [CREDIT_W-1:0] credit_o
);
  always_comb begin
    pay_25   = en && hopper_ready && credit >= CREDIT_W'(COIN_25);
    pay_10   = en && hopper_ready && !pay_25 && credit >= CREDIT_W'(COIN_10);
    pay_5    = en && hopper_ready && !pay_25 && !pay_10 && credit >= CREDIT_W'(COIN_5);
    credit_o = credit - (pay_25 ? CREDIT_W'(COIN_25) : pay_10 ? CREDIT_W'(COIN_10) :
                         pay_5 ? CREDIT_W'(COIN_5) : '0);
  end
endmodule

// File: rtl/vending_controller.sv
// vending_controller: coin-collecting item vending FSM with timed dispense and greedy change
// Inputs: clk, reset (sync, active-high), coin_5/10/25 pulses, next_item/select/cancel raw buttons, hopper_ready
// Outputs: dispense, item_sel, credit, coin_reject, pay_5/10/25 pulses, busy, sold_out
// Optional: define VENDING_STOCK_EN for per-item stock tracking (sold_out is 0 otherwise)
module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int CREDIT_W    = 8,
  parameter int PRICES [NUM_ITEMS] = '{25, 50, 100, 200},
  parameter int HOLD_CYCLES = 125000000,
  parameter int STOCK_INIT  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coin_5,
  input  logic                         coin_10,
  input  logic                         coin_25,
  input  logic                         next_item,
  input  logic                         select,
  input  logic                         cancel,
  input  logic                         hopper_ready,
  output logic                         dispense,
  output logic [$clog2(NUM_ITEMS)-1:0] item_sel,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         coin_reject,
  output logic                         pay_5,
  output logic                         pay_10,
  output logic                         pay_25,
  output logic                         busy,
  output logic                         sold_out
);
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, price, pay_credit;
  logic [IW-1:0] item_sel_q, item_sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic reject_q, reject_d;
  logic [2:0] btn_q;
  logic next_e, sel_e, can_e, any_coin, multi;
  logic [CREDIT_W:0] coin_val, sum;
  assign {next_e, sel_e, can_e} = {next_item, select, cancel} & ~btn_q;
  assign price    = CREDIT_W'(PRICES[item_sel_q]);
  assign any_coin = coin_5 | coin_10 | coin_25;
  assign multi    = (coin_5 & coin_10) | (coin_5 & coin_25) | (coin_10 & coin_25);
  assign coin_val = coin_25 ? (CREDIT_W+1)'(COIN_25) : coin_10 ? (CREDIT_W+1)'(COIN_10) :
                    coin_5 ? (CREDIT_W+1)'(COIN_5) : '0;
  assign sum      = {1'b0, credit_q} + coin_val;
  change_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .en(state_q == CHANGE), .hopper_ready(hopper_ready), .credit(credit_q),
    .pay_5(pay_5), .pay_10(pay_10), .pay_25(pay_25), .credit_o(pay_credit)
  );
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_sel_d = item_sel_q;
    hold_d     = hold_q;
    reject_d   = 1'b0;
    if (state_q == IDLE || state_q == COLLECTING) begin
      if (any_coin && sum[CREDIT_W]) reject_d = 1'b1;
      else if (any_coin) begin
        credit_d = sum[CREDIT_W-1:0];
        reject_d = multi;
        if (state_q == IDLE) state_d = COLLECTING;
      end
      if (next_e) item_sel_d = item_sel_q == IW'(NUM_ITEMS - 1) ? '0 : item_sel_q + 1'b1;
      if (state_q == COLLECTING && sel_e && credit_q >= price && !sold_out) state_d = VEND;
      else if (state_q == COLLECTING && can_e) state_d = CHANGE;
    end else reject_d = any_coin;
    if (state_q == VEND) begin
      credit_d = credit_q - price;
      hold_d   = '0;
      state_d  = HOLD;
    end
    if (state_q == HOLD) begin
      hold_d = hold_q == HW'(HOLD_CYCLES - 1) ? '0 : hold_q + 1'b1;
      if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = credit_q != '0 ? CHANGE : IDLE;
    end
    if (state_q == CHANGE) begin
      credit_d = pay_credit;
      if (pay_credit == '0) state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item_sel_q <= '0;
      hold_q     <= '0;
      reject_q   <= 1'b0;
      btn_q      <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_sel_q <= item_sel_d;
      hold_q     <= hold_d;
      reject_q   <= reject_d;
      btn_q      <= {next_item, select, cancel};
    end
  end
`ifdef VENDING_STOCK_EN
  localparam int SW = $clog2(STOCK_INIT + 1) + 1;
  logic [SW-1:0] stock_q [NUM_ITEMS];
  logic [SW-1:0] stock_d [NUM_ITEMS];
  always_comb begin
    stock_d = stock_q;
    if (state_q == VEND) stock_d[item_sel_q] = stock_q[item_sel_q] - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= SW'(STOCK_INIT);
    else stock_q <= stock_d;
  end
  assign sold_out = stock_q[item_sel_q] == '0;
`else
  assign sold_out = 1'b0;
`endif
  assign dispense    = state_q == HOLD;
  assign busy        = state_q == VEND || state_q == HOLD || state_q == CHANGE;
  assign credit      = credit_q;
  assign item_sel    = item_sel_q;
  assign coin_reject = reject_q;
endmodule
